// File: rtl/axis_spi_pkg.sv
// Shared types and constants for the SPI command sequencer.
`timescale 1ns/1ps
package axis_spi_pkg;
  localparam int BYTE_W   = 8;
  localparam int ADDR_W   = 7;
  localparam int RW_BIT   = 7;
  localparam int ADDR_MSB = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WR_DATA,
    S_WR_WAIT,
    S_RD_REQ,
    S_RD_WAIT,
    S_RD_HOLD,
    S_DRAIN
  } state_e;
endpackage

// File: rtl/axis_spi_txbuf.sv
// One-entry tx holding register; flush beats load, load beats handshake.
// Loaded data is visible one cycle after the load request.
`timescale 1ns/1ps
module axis_spi_txbuf
  import axis_spi_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [BYTE_W-1:0] load_dat_i,
  input  logic              flush_i,
  input  logic              tready_i,
  output logic [BYTE_W-1:0] tdata_o,
  output logic              tvalid_o
);
  logic [BYTE_W-1:0] dat_q;
  logic              vld_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dat_q <= '0;
      vld_q <= 1'b0;
    end else if (flush_i) begin
      vld_q <= 1'b0;
    end else if (load_i) begin
      dat_q <= load_dat_i;
      vld_q <= 1'b1;
    end else if (tready_i && vld_q) begin
      vld_q <= 1'b0;
    end
  end

  assign tdata_o  = dat_q;
  assign tvalid_o = vld_q;
endmodule

// File: rtl/axis_spi_reg_ctrl.sv
// SPI frame sequencer: command byte then auto-incrementing register writes or prefetched reads.
// rx is backpressured while a write waits for reg_ack; one register access outstanding at a time.
`timescale 1ns/1ps
module axis_spi_reg_ctrl
  import axis_spi_pkg::*;
#(
  parameter logic [7:0]  C_DUMMY_BYTE  = 8'h00,
  parameter int unsigned C_ACK_TIMEOUT = 16,
  parameter logic [7:0]  C_ERR_BYTE    = 8'hFF
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              ss_n,
  input  logic [BYTE_W-1:0] axis_rx_tdata,
  input  logic              axis_rx_tvalid,
  output logic              axis_rx_tready,
  output logic [BYTE_W-1:0] axis_tx_tdata,
  output logic              axis_tx_tvalid,
  input  logic              axis_tx_tready,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_wr,
  output logic              reg_rd,
  output logic [BYTE_W-1:0] reg_wdata,
  input  logic [BYTE_W-1:0] reg_rdata,
  input  logic              reg_ack,
  output logic              busy,
  output logic              err_timeout,
  output logic              err_underrun
);
  localparam int CNT_W = $clog2(C_ACK_TIMEOUT);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BYTE_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              reg_wr_q, reg_rd_q, ss_q, rx_rdy_q, err_to_q, err_ur_q;

  logic              tx_vld, tx_load, tx_flush;
  logic [BYTE_W-1:0] tx_load_dat;
  logic              rx_hs, tx_hs, tmo;

  assign rx_hs    = axis_rx_tvalid & rx_rdy_q;
  assign tx_hs    = tx_vld & axis_tx_tready;
  assign tmo      = (cnt_q == CNT_W'(C_ACK_TIMEOUT - 1));
  assign tx_flush = ss_n & ~ss_q;

  always_comb begin
    tx_load     = 1'b0;
    tx_load_dat = C_DUMMY_BYTE;
    case (state_q)
      S_IDLE:               tx_load = ~tx_vld;
      S_CMD:                tx_load = rx_hs & ~axis_rx_tdata[RW_BIT];
      S_WR_DATA, S_WR_WAIT: tx_load = ~tx_vld | tx_hs;
      S_RD_WAIT: begin
        tx_load     = reg_ack | tmo;
        tx_load_dat = reg_ack ? reg_rdata : C_ERR_BYTE;
      end
      default: ;
    endcase
  end

  axis_spi_txbuf u_txbuf (
    .clk_i      (aclk),
    .rst_i      (areset),
    .load_i     (tx_load),
    .load_dat_i (tx_load_dat),
    .flush_i    (tx_flush),
    .tready_i   (axis_tx_tready),
    .tdata_o    (axis_tx_tdata),
    .tvalid_o   (tx_vld)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      reg_wr_q <= 1'b0;
      reg_rd_q <= 1'b0;
      ss_q     <= 1'b1;
      rx_rdy_q <= 1'b0;
      err_to_q <= 1'b0;
      err_ur_q <= 1'b0;
    end else begin
      ss_q     <= ss_n;
      rx_rdy_q <= 1'b1;
      cnt_q    <= '0;
      if (axis_tx_tready && !tx_vld && !ss_n) err_ur_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (!ss_n) begin
            state_q  <= S_CMD;
            err_to_q <= 1'b0;
            err_ur_q <= 1'b0;
          end
        end
        S_CMD: begin
          if (ss_n) begin
            state_q <= S_IDLE;
          end else if (rx_hs) begin
            addr_q  <= axis_rx_tdata[ADDR_MSB:0];
            state_q <= axis_rx_tdata[RW_BIT] ? S_RD_REQ : S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          // A beat arriving with the SS edge is still written, then drained.
          if (rx_hs) begin
            reg_wr_q <= 1'b1;
            wdata_q  <= axis_rx_tdata;
            rx_rdy_q <= 1'b0;
            state_q  <= ss_n ? S_DRAIN : S_WR_WAIT;
          end else if (ss_n) begin
            state_q <= S_IDLE;
          end
        end
        S_WR_WAIT, S_RD_WAIT, S_DRAIN: begin
          if (reg_ack || tmo) begin
            reg_wr_q <= 1'b0;
            reg_rd_q <= 1'b0;
            addr_q   <= addr_q + 7'd1;
            if (!reg_ack) err_to_q <= 1'b1;
            if (ss_n || state_q == S_DRAIN) state_q <= S_IDLE;
            else if (state_q == S_WR_WAIT)  state_q <= S_WR_DATA;
            else                            state_q <= S_RD_HOLD;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (state_q == S_WR_WAIT) rx_rdy_q <= 1'b0;
            if (ss_n) state_q <= S_DRAIN;
          end
        end
        S_RD_REQ: begin
          if (ss_n) begin
            state_q <= S_IDLE;
          end else begin
            reg_rd_q <= 1'b1;
            state_q  <= S_RD_WAIT;
          end
        end
        S_RD_HOLD: begin
          if (ss_n)       state_q <= S_IDLE;
          else if (tx_hs) state_q <= S_RD_REQ;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign axis_rx_tready = rx_rdy_q;
  assign axis_tx_tvalid = tx_vld;
  assign reg_addr       = addr_q;
  assign reg_wr         = reg_wr_q;
  assign reg_rd         = reg_rd_q;
  assign reg_wdata      = wdata_q;
  assign busy           = (state_q != S_IDLE) | reg_wr_q | reg_rd_q;
  assign err_timeout    = err_to_q;
  assign err_underrun   = err_ur_q;
endmodule

// File: tb/tb_axis_spi_reg_ctrl.sv
// Scoreboard bench: tx bytes and register accesses are queued as issued and checked by monitors.
`timescale 1ns/1ps
module tb_axis_spi_reg_ctrl;
  logic       aclk = 1'b0;
  logic       areset = 1'b1;
  logic       ss_n = 1'b1;
  logic [7:0] axis_rx_tdata = 8'h00;
  logic       axis_rx_tvalid = 1'b0;
  logic       axis_rx_tready;
  logic [7:0] axis_tx_tdata;
  logic       axis_tx_tvalid;
  logic       axis_tx_tready = 1'b0;
  logic [6:0] reg_addr;
  logic       reg_wr, reg_rd;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata = 8'h00;
  logic       reg_ack = 1'b0;
  logic       busy, err_timeout, err_underrun;

  axis_spi_reg_ctrl dut (
    .aclk(aclk), .areset(areset), .ss_n(ss_n),
    .axis_rx_tdata(axis_rx_tdata), .axis_rx_tvalid(axis_rx_tvalid), .axis_rx_tready(axis_rx_tready),
    .axis_tx_tdata(axis_tx_tdata), .axis_tx_tvalid(axis_tx_tvalid), .axis_tx_tready(axis_tx_tready),
    .reg_addr(reg_addr), .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .reg_ack(reg_ack), .busy(busy),
    .err_timeout(err_timeout), .err_underrun(err_underrun)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic       wr;
    logic [6:0] addr;
    logic [7:0] dat;
  } acc_t;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] tx_exp_q[$];
  acc_t       acc_exp_q[$];
  logic       resp_en = 1'b1;
  int         ack_dly = 2;
  logic       strobe_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_acc(input logic wr, input logic [6:0] a, input logic [7:0] d);
    acc_t e;
    e.wr = wr; e.addr = a; e.dat = d;
    acc_exp_q.push_back(e);
  endtask

  // Tx monitor: a handshake completes at the next rising edge.
  initial forever begin
    @(negedge aclk);
    if (!areset && axis_tx_tready && axis_tx_tvalid) begin
      if (tx_exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL tx_extra: got 0x%0h, expected no tx byte", axis_tx_tdata);
      end else begin
        check("tx_byte", {24'h0, axis_tx_tdata}, {24'h0, tx_exp_q.pop_front()});
      end
    end
  end

  // Register access monitor: each new strobe is one access.
  initial forever begin
    acc_t e;
    @(negedge aclk);
    if ((reg_wr || reg_rd) && !strobe_prev) begin
      if (acc_exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL acc_extra: got wr=%0b addr=0x%0h, expected no access", reg_wr, reg_addr);
      end else begin
        e = acc_exp_q.pop_front();
        check("acc_kind", {31'h0, reg_wr}, {31'h0, e.wr});
        check("acc_addr", {25'h0, reg_addr}, {25'h0, e.addr});
        if (e.wr) check("acc_wdata", {24'h0, reg_wdata}, {24'h0, e.dat});
      end
    end
    strobe_prev = reg_wr | reg_rd;
  end

  // Register bus responder: ack after ack_dly cycles, rdata = addr + 0x40.
  initial begin
    int w;
    w = 0;
    forever begin
      @(negedge aclk);
      reg_ack = 1'b0;
      if ((reg_wr || reg_rd) && resp_en) begin
        w++;
        if (w >= ack_dly) begin
          reg_ack   = 1'b1;
          reg_rdata = 8'h40 + {1'b0, reg_addr};
          w = 0;
        end
      end else begin
        w = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge aclk); #1;
  endtask

  task automatic take_tx();
    int n = 0;
    while (!axis_tx_tvalid && n < 100) begin tick(); n++; end
    if (!axis_tx_tvalid) begin
      vectors++; miscompares++;
      $display("FAIL tx_wait: tvalid=0, expected 1 within 100 cycles");
    end else begin
      axis_tx_tready = 1'b1; tick(); axis_tx_tready = 1'b0;
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    int n = 0;
    axis_rx_tdata = b; axis_rx_tvalid = 1'b1;
    while (!axis_rx_tready && n < 100) begin tick(); n++; end
    if (!axis_rx_tready) begin
      vectors++; miscompares++;
      $display("FAIL rx_wait: tready=0, expected 1 within 100 cycles");
    end else begin
      tick();
    end
    axis_rx_tvalid = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    take_tx(); tick(); send_rx(b);
  endtask

  task automatic start_frame();
    ss_n = 1'b0; tick(); tick();
  endtask

  task automatic end_frame(input string name);
    int n = 0;
    ss_n = 1'b1;
    while (busy && n < 100) begin tick(); n++; end
    check(name, {31'h0, busy}, 32'h0);
    tick(); tick();
  endtask

  initial begin
    int n;
    repeat (3) tick();
    check("rst_tvalid", {31'h0, axis_tx_tvalid}, 32'h0);
    check("rst_rx_tready", {31'h0, axis_rx_tready}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    areset = 1'b0; tick();
    check("preload_vld", {31'h0, axis_tx_tvalid}, 32'h1);
    check("preload_dat", {24'h0, axis_tx_tdata}, 32'h0);

    // Write burst
    ack_dly = 2;
    tx_exp_q.push_back(8'h00); tx_exp_q.push_back(8'h00); tx_exp_q.push_back(8'h00);
    exp_acc(1'b1, 7'h10, 8'hAA); exp_acc(1'b1, 7'h11, 8'hBB);
    start_frame(); spi_byte(8'h10); spi_byte(8'hAA); spi_byte(8'hBB);
    repeat (6) tick();
    end_frame("wr_idle");

    // Read burst with a prefetch drained after SS rises
    ack_dly = 8;
    tx_exp_q.push_back(8'h00); tx_exp_q.push_back(8'h45);
    tx_exp_q.push_back(8'h46); tx_exp_q.push_back(8'h47);
    exp_acc(1'b0, 7'h05, 8'h00); exp_acc(1'b0, 7'h06, 8'h00);
    exp_acc(1'b0, 7'h07, 8'h00); exp_acc(1'b0, 7'h08, 8'h00);
    start_frame(); spi_byte(8'h85); spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'h00);
    ss_n = 1'b1; tick();
    check("drain_rd_held", {31'h0, reg_rd}, 32'h1);
    check("drain_busy", {31'h0, busy}, 32'h1);
    end_frame("rd_idle");
    check("rd_no_err", {30'h0, err_timeout, err_underrun}, 32'h0);

    // Timeout read with an underrun pulse while waiting
    resp_en = 1'b0;
    tx_exp_q.push_back(8'h00);
    exp_acc(1'b0, 7'h03, 8'h00);
    start_frame(); spi_byte(8'h83);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge aclk);
      if (reg_rd) n++;
      else if (n > 0) break;
      axis_tx_tready = (n == 3);
    end
    axis_tx_tready = 1'b0;
    check("timeout_hold", n, 32'd16);
    check("timeout_err", {31'h0, err_timeout}, 32'h1);
    check("underrun_err", {31'h0, err_underrun}, 32'h1);
    check("timeout_tvalid", {31'h0, axis_tx_tvalid}, 32'h1);
    tick();
    resp_en = 1'b1; ack_dly = 2;
    tx_exp_q.push_back(8'hFF);
    exp_acc(1'b0, 7'h04, 8'h00);
    take_tx();
    repeat (6) tick();
    end_frame("to_idle");
    check("timeout_sticky", {31'h0, err_timeout}, 32'h1);

    // Wrap-around write; frame start clears sticky errors
    tx_exp_q.push_back(8'h00); tx_exp_q.push_back(8'h00); tx_exp_q.push_back(8'h00);
    exp_acc(1'b1, 7'h7F, 8'h11); exp_acc(1'b1, 7'h00, 8'h22);
    start_frame();
    check("err_cleared", {30'h0, err_timeout, err_underrun}, 32'h0);
    spi_byte(8'h7F); spi_byte(8'h11); spi_byte(8'h22);
    repeat (6) tick();
    end_frame("wrap_idle");

    // Reset while a write waits for ack
    resp_en = 1'b0;
    tx_exp_q.push_back(8'h00); tx_exp_q.push_back(8'h00);
    exp_acc(1'b1, 7'h20, 8'h5A);
    start_frame(); spi_byte(8'h20); spi_byte(8'h5A); tick();
    check("pre_reset_wr", {31'h0, reg_wr}, 32'h1);
    areset = 1'b1; ss_n = 1'b1; tick();
    check("mid_rst_strobes", {30'h0, reg_wr, reg_rd}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_tx", {23'h0, axis_tx_tvalid, axis_tx_tdata}, 32'h0);
    check("mid_rst_rx_tready", {31'h0, axis_rx_tready}, 32'h0);
    check("mid_rst_bus", {17'h0, reg_addr, reg_wdata}, 32'h0);
    areset = 1'b0; tick();
    resp_en = 1'b1;
    check("post_rst_vld", {31'h0, axis_tx_tvalid}, 32'h1);
    check("post_rst_dat", {24'h0, axis_tx_tdata}, 32'h0);
    check("post_rst_rx_tready", {31'h0, axis_rx_tready}, 32'h1);
    repeat (4) tick();

    check("tx_queue_empty", tx_exp_q.size(), 32'h0);
    check("acc_queue_empty", acc_exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
